// File: rtl/wb_stage.sv
// Writeback stage of a Y86-64 pipeline.
// Holds the W pipeline register, drives the register-file write ports with
// bubble/exception suppression and the popq %rsp priority rule, and owns
// processor status: the RUN/HALT machine, the external Stat code and the
// saturating retired-instruction counter.
module wb_stage #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       M_stat,
  input  logic [3:0]       M_icode,
  input  logic [63:0]      M_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       M_dstE,
  input  logic [3:0]       M_dstM,
  input  logic             W_stall,
  input  logic             W_bubble,
  output logic [3:0]       W_icode,
  output logic [3:0]       W_stat,
  output logic [3:0]       dstE,
  output logic [63:0]      valE,
  output logic [3:0]       dstM,
  output logic [63:0]      valM,
  output logic [3:0]       Stat,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  // Status codes carried down the pipe.
  localparam logic [3:0] STAT_BUB = 4'h0;
  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_HLT = 4'h2;
  localparam logic [3:0] STAT_ADR = 4'h3;
  localparam logic [3:0] STAT_INS = 4'h4;

  // Register id meaning "no write", and the nop icode a bubble carries.
  localparam logic [3:0] REG_NONE  = 4'hF;
  localparam logic [3:0] ICODE_NOP = 4'h1;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t state;

  // Internal W register fields that are not ports themselves.
  logic [63:0] w_vale;
  logic [63:0] w_valm;
  logic [3:0]  w_dste;
  logic [3:0]  w_dstm;

  // Any code outside the defined set is an invalid instruction, so the
  // rest of the stage only ever sees BUB/AOK/HLT/ADR/INS.
  function automatic logic [3:0] norm_stat(input logic [3:0] s);
    if (s > STAT_INS) return STAT_INS;
    else              return s;
  endfunction

  logic [3:0] m_stat_n;
  logic       m_is_exc;
  logic       run;
  logic       bubble_en;
  logic       load_en;

  assign m_stat_n  = norm_stat(M_stat);
  assign m_is_exc  = (m_stat_n == STAT_HLT) || (m_stat_n == STAT_ADR) ||
                     (m_stat_n == STAT_INS);
  assign run       = (state == RUN);
  // Bubble beats stall; in HALT neither has any effect.
  assign bubble_en = run && W_bubble;
  assign load_en   = run && !W_bubble && !W_stall;

  // W pipeline register: reset/bubble load a nop, stall or HALT holds.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    if (!rst_n || bubble_en) begin
      W_stat  <= STAT_BUB;
      W_icode <= ICODE_NOP;
      w_vale  <= '0;
      w_valm  <= '0;
      w_dste  <= REG_NONE;
      w_dstm  <= REG_NONE;
    end else if (load_en) begin
      W_stat  <= m_stat_n;
      W_icode <= M_icode;
      w_vale  <= M_valE;
      w_valm  <= m_valM;
      w_dste  <= M_dstE;
      w_dstm  <= M_dstM;
    end
  end

  // Status machine: the edge that loads an exception into W also halts,
  // so Stat/halted appear together with the offending W contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      halted <= 1'b0;
      Stat   <= STAT_AOK;
    end else begin
      case (state)
        RUN: begin
          if (load_en && m_is_exc) begin
            state  <= HALT;
            halted <= 1'b1;
            Stat   <= m_stat_n;
          end
        end
        HALT: begin
          // Frozen until reset.
          state  <= HALT;
          halted <= 1'b1;
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
          Stat   <= STAT_AOK;
        end
      endcase
    end
  end

  // Retired counter: one count per AOK instruction entering W, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (load_en && (m_stat_n == STAT_AOK) && (retired != CNT_MAX)) begin
      retired <= retired + CNT_W'(1);
    end
  end

  // Register-file write ports, derived from the W register alone so they
  // stay stable through the low phase when the file commits.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    dstE = REG_NONE;
    dstM = REG_NONE;
    valE = w_vale;
    valM = w_valm;
    if (W_stat == STAT_AOK) begin
      dstM = w_dstm;
      // popq %rsp: both ports target the same register; the memory value wins.
      if ((w_dste == w_dstm) && (w_dste != REG_NONE)) dstE = REG_NONE;
      else                                            dstE = w_dste;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: reset, normal writes, popq
// priority, stall/bubble, exception halt, reset out of HALT, unknown status
// codes and counter saturation (second instance with a 4-bit counter).
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  M_stat;
  logic [3:0]  M_icode;
  logic [63:0] M_valE;
  logic [63:0] m_valM;
  logic [3:0]  M_dstE;
  logic [3:0]  M_dstM;
  logic        W_stall;
  logic        W_bubble;

  logic [3:0]  W_icode, W_stat, dstE, dstM, Stat;
  logic [63:0] valE, valM;
  logic        halted;
  logic [31:0] retired;

  logic [3:0]  W_icode4, W_stat4, dstE4, dstM4, Stat4;
  logic [63:0] valE4, valM4;
  logic        halted4;
  logic [3:0]  retired4;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_stage #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
    .W_icode(W_icode), .W_stat(W_stat), .dstE(dstE), .valE(valE),
    .dstM(dstM), .valM(valM), .Stat(Stat), .halted(halted), .retired(retired)
  );

  wb_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_icode(M_icode), .M_valE(M_valE), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_dstM(M_dstM), .W_stall(W_stall), .W_bubble(W_bubble),
    .W_icode(W_icode4), .W_stat(W_stat4), .dstE(dstE4), .valE(valE4),
    .dstM(dstM4), .valM(valM4), .Stat(Stat4), .halted(halted4), .retired(retired4)
  );

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic [3:0] st, input logic [3:0] ic,
                         input logic [63:0] ve, input logic [63:0] vm,
                         input logic [3:0] de, input logic [3:0] dm);
    M_stat  = st;
    M_icode = ic;
    M_valE  = ve;
    m_valM  = vm;
    M_dstE  = de;
    M_dstM  = dm;
  endtask

  task automatic do_reset();
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    rst_n    = 1'b0;
    tick();
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    drive_m(4'h1, 4'h6, 64'hDEAD, 64'hBEEF, 4'h2, 4'h3);
    W_stall  = 1'b1;
    W_bubble = 1'b0;
    rst_n    = 1'b0;
    tick();
    total_cnt++;
    if ({W_stat, W_icode, dstE, dstM} !== {4'h0, 4'h1, 4'hF, 4'hF})
      $display("FAIL reset_w: stat/icode/dstE/dstM got %h required 01FF",
               {W_stat, W_icode, dstE, dstM});
    else pass_cnt++;
    total_cnt++;
    if ({valE, valM} !== 128'h0)
      $display("FAIL reset_vals: valE=%h valM=%h required 0", valE, valM);
    else pass_cnt++;
    total_cnt++;
    if ({Stat, halted, retired} !== {4'h1, 1'b0, 32'd0})
      $display("FAIL reset_status: Stat=%h halted=%b retired=%0d required 1/0/0",
               Stat, halted, retired);
    else pass_cnt++;
    rst_n   = 1'b1;
    W_stall = 1'b0;
  endtask

  task automatic test_basic_write();
    drive_m(4'h1, 4'h6, 64'h15, 64'h0, 4'h3, 4'hF);
    tick();
    total_cnt++;
    if ({dstE, valE, dstM} !== {4'h3, 64'h15, 4'hF})
      $display("FAIL basic_write: dstE=%h valE=%h dstM=%h required 3/15/F",
               dstE, valE, dstM);
    else pass_cnt++;
    total_cnt++;
    if ({retired, Stat, W_stat, W_icode} !== {32'd1, 4'h1, 4'h1, 4'h6})
      $display("FAIL basic_status: retired=%0d Stat=%h W_stat=%h W_icode=%h required 1/1/1/6",
               retired, Stat, W_stat, W_icode);
    else pass_cnt++;
  endtask

  task automatic test_popq();
    drive_m(4'h1, 4'hB, 64'h108, 64'hABC, 4'h4, 4'h4);
    tick();
    total_cnt++;
    if ({dstE, dstM, valM, valE} !== {4'hF, 4'h4, 64'hABC, 64'h108})
      $display("FAIL popq_rsp: dstE=%h dstM=%h valM=%h valE=%h required F/4/ABC/108",
               dstE, dstM, valM, valE);
    else pass_cnt++;
    total_cnt++;
    if (retired !== 32'd2)
      $display("FAIL popq_retired: got %0d required 2", retired);
    else pass_cnt++;
  endtask

  task automatic test_dual_write();
    // Distinct destinations: both ports must write.
    drive_m(4'h1, 4'hB, 64'h200, 64'h77, 4'h4, 4'h5);
    tick();
    total_cnt++;
    if ({dstE, dstM, valE, valM} !== {4'h4, 4'h5, 64'h200, 64'h77})
      $display("FAIL dual_write: dstE=%h dstM=%h valE=%h valM=%h required 4/5/200/77",
               dstE, dstM, valE, valM);
    else pass_cnt++;
    // Upstream bubble arriving from M: no write, not counted, Stat still AOK.
    drive_m(4'h0, 4'h1, 64'h0, 64'h0, 4'h6, 4'h7);
    tick();
    total_cnt++;
    if ({W_stat, dstE, dstM, Stat, retired} !== {4'h0, 4'hF, 4'hF, 4'h1, 32'd3})
      $display("FAIL m_bubble: W_stat=%h dstE=%h dstM=%h Stat=%h retired=%0d required 0/F/F/1/3",
               W_stat, dstE, dstM, Stat, retired);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    do_reset();
    drive_m(4'h1, 4'h3, 64'h77, 64'h0, 4'h5, 4'hF);
    tick();
    total_cnt++;
    if ({dstE, valE, retired} !== {4'h5, 64'h77, 32'd1})
      $display("FAIL stall_load: dstE=%h valE=%h retired=%0d required 5/77/1",
               dstE, valE, retired);
    else pass_cnt++;
    W_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_m(4'h1, 4'h6, 64'h100 + 64'(i), 64'h1, 4'h9, 4'h8);
      tick();
      total_cnt++;
      if ({dstE, valE, dstM, W_icode, retired} !== {4'h5, 64'h77, 4'hF, 4'h3, 32'd1})
        $display("FAIL stall_hold%0d: dstE=%h valE=%h dstM=%h icode=%h retired=%0d required 5/77/F/3/1",
                 i, dstE, valE, dstM, W_icode, retired);
      else pass_cnt++;
    end
    W_bubble = 1'b1;
    tick();
    total_cnt++;
    if ({W_stat, W_icode, dstE, dstM, Stat, retired} !== {4'h0, 4'h1, 4'hF, 4'hF, 4'h1, 32'd1})
      $display("FAIL stall_bubble: stat=%h icode=%h dstE=%h dstM=%h Stat=%h retired=%0d required 0/1/F/F/1/1",
               W_stat, W_icode, dstE, dstM, Stat, retired);
    else pass_cnt++;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
  endtask

  task automatic test_halt();
    drive_m(4'h3, 4'h5, 64'h40, 64'h99, 4'hF, 4'h2);
    tick();
    total_cnt++;
    if ({W_stat, dstM, dstE, halted, Stat, retired} !== {4'h3, 4'hF, 4'hF, 1'b1, 4'h3, 32'd1})
      $display("FAIL halt_adr: W_stat=%h dstM=%h dstE=%h halted=%b Stat=%h retired=%0d required 3/F/F/1/3/1",
               W_stat, dstM, dstE, halted, Stat, retired);
    else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      drive_m(4'h1, 4'h6, 64'h500 + 64'(i), 64'h0, 4'h6, 4'hF);
      W_bubble = (i % 2) == 1;
      W_stall  = (i == 2);
      tick();
      total_cnt++;
      if ({W_stat, W_icode, valE, halted, Stat, retired} !== {4'h3, 4'h5, 64'h40, 1'b1, 4'h3, 32'd1})
        $display("FAIL halt_frozen%0d: W_stat=%h icode=%h valE=%h halted=%b Stat=%h retired=%0d required 3/5/40/1/3/1",
                 i, W_stat, W_icode, valE, halted, Stat, retired);
      else pass_cnt++;
    end
    W_bubble = 1'b0;
    W_stall  = 1'b0;
  endtask

  task automatic test_reset_in_halt();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total_cnt++;
    if ({W_stat, halted, Stat, retired} !== {4'h0, 1'b0, 4'h1, 32'd0})
      $display("FAIL halt_reset: W_stat=%h halted=%b Stat=%h retired=%0d required 0/0/1/0",
               W_stat, halted, Stat, retired);
    else pass_cnt++;
    drive_m(4'h1, 4'h2, 64'h2A, 64'h0, 4'h7, 4'hF);
    tick();
    total_cnt++;
    if ({dstE, valE, retired, halted} !== {4'h7, 64'h2A, 32'd1, 1'b0})
      $display("FAIL post_reset_retire: dstE=%h valE=%h retired=%0d halted=%b required 7/2A/1/0",
               dstE, valE, retired, halted);
    else pass_cnt++;
  endtask

  task automatic test_exceptions();
    do_reset();
    drive_m(4'h2, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF);
    tick();
    total_cnt++;
    if ({Stat, halted, W_icode, retired} !== {4'h2, 1'b1, 4'h0, 32'd0})
      $display("FAIL halt_hlt: Stat=%h halted=%b icode=%h retired=%0d required 2/1/0/0",
               Stat, halted, W_icode, retired);
    else pass_cnt++;
    do_reset();
    // Undefined status code behaves as INS; destination must not be written.
    drive_m(4'h9, 4'h6, 64'h11, 64'h0, 4'h1, 4'hF);
    tick();
    total_cnt++;
    if ({W_stat, Stat, halted, dstE, retired} !== {4'h4, 4'h4, 1'b1, 4'hF, 32'd0})
      $display("FAIL unknown_stat: W_stat=%h Stat=%h halted=%b dstE=%h retired=%0d required 4/4/1/F/0",
               W_stat, Stat, halted, dstE, retired);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive_m(4'h1, 4'h6, 64'(i), 64'h0, 4'h1, 4'hF);
      tick();
      if (i == 14) begin
        total_cnt++;
        if (retired4 !== 4'hF)
          $display("FAIL sat_reach: retired4=%h required F after 15 loads", retired4);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (retired4 !== 4'hF)
      $display("FAIL sat_hold: retired4=%h required F after 17 loads", retired4);
    else pass_cnt++;
    total_cnt++;
    if (retired !== 32'd17)
      $display("FAIL wide_count: retired=%0d required 17", retired);
    else pass_cnt++;
  endtask

  initial begin
    rst_n    = 1'b0;
    W_stall  = 1'b0;
    W_bubble = 1'b0;
    drive_m(4'h0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);
    #2;
    test_reset();
    test_basic_write();
    test_popq();
    test_dual_write();
    test_stall();
    test_halt();
    test_reset_in_halt();
    test_exceptions();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
